// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with combinational reads, clocked
// prioritised writes, optional hardwired zero entry and a scrub engine that zeroes
// the whole array after reset or on a clear request.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp #(
    parameter int unsigned REGISTER_COUNT = 32,
    parameter int unsigned DATA_LENGTH    = 32,
    parameter int unsigned READ_PORTS     = 2,
    parameter int unsigned WRITE_PORTS    = 2,
    parameter int unsigned ZERO_REG       = 1,
    // Floor of 1 keeps a single-entry file from producing zero-width vectors.
    localparam int unsigned AW = (REGISTER_COUNT > 1) ? $clog2(REGISTER_COUNT) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [READ_PORTS*AW-1:0]          r_addr_i,
    output logic [READ_PORTS*DATA_LENGTH-1:0] r_data_o,
    input  logic [WRITE_PORTS*AW-1:0]         w_addr_i,
    input  logic [WRITE_PORTS*DATA_LENGTH-1:0] w_data_i,
    input  logic [WRITE_PORTS-1:0]            w_ctrl_i,
    input  logic                              clr_i,
    output logic                              ready_o
);

    typedef enum logic [0:0] {StScrub, StReady} state_e;

    state_e                   state_q, state_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic [DATA_LENGTH-1:0]   mem_q [REGISTER_COUNT];
    logic [DATA_LENGTH-1:0]   mem_d [REGISTER_COUNT];
    logic [WRITE_PORTS-1:0]   wr_ok;

    // An address names a real, writable/readable entry (not out of range, not hardwired zero).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < REGISTER_COUNT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign ready_o = (state_q == StReady);

    // Qualify each write port: only lands in READY, and never on a clear or reset edge.
    always_comb begin
        wr_ok = '0;
        for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
            wr_ok[j] = w_ctrl_i[j] && (state_q == StReady) && !clr_i && !rst_i
                       && addr_ok(w_addr_i[j*AW +: AW]);
        end
    end

    // Next-state logic for the scrub/ready FSM and the scrub counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StScrub: begin
                cnt_d = cnt_q + AW'(1);
                // Compare against the last entry so non-power-of-two sizes stop without wrap.
                if (cnt_q == AW'(REGISTER_COUNT - 1)) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end
            end
            StReady: begin
                if (clr_i) begin
                    state_d = StScrub;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StScrub;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; synchronous reset restarts the scrub from entry 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StScrub;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array next-state: scrub zeroes one entry per cycle, otherwise apply qualified writes.
    // Ports are visited in ascending order so the highest-index port wins a conflict.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned k = 0; k < REGISTER_COUNT; k++) begin
            if (state_q == StScrub) begin
                if (cnt_q == AW'(k)) begin
                    mem_d[k] = '0;
                end
            end else begin
                for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
                    if (wr_ok[j] && (w_addr_i[j*AW +: AW] == AW'(k))) begin
                        mem_d[k] = w_data_i[j*DATA_LENGTH +: DATA_LENGTH];
                    end
                end
            end
        end
    end

    // Storage array; contents need no reset because the scrub clears them.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Combinational read ports, forced to zero in SCRUB and for invalid/zero addresses.
    always_comb begin
        r_data_o = '0;
        for (int unsigned i = 0; i < READ_PORTS; i++) begin
            if ((state_q == StReady) && addr_ok(r_addr_i[i*AW +: AW])) begin
                for (int unsigned k = 0; k < REGISTER_COUNT; k++) begin
                    if (r_addr_i[i*AW +: AW] == AW'(k)) begin
                        r_data_o[i*DATA_LENGTH +: DATA_LENGTH] = mem_q[k];
                    end
                end
`ifdef REGFILE_BYPASS_EN
                // Forward a same-cycle landing write; later ports override earlier ones.
                for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
                    if (wr_ok[j] && (w_addr_i[j*AW +: AW] == r_addr_i[i*AW +: AW])) begin
                        r_data_o[i*DATA_LENGTH +: DATA_LENGTH] =
                            w_data_i[j*DATA_LENGTH +: DATA_LENGTH];
                    end
                end
`else
                // Reads see stored contents only; writes become visible after the edge.
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (32 entries with zero register, 24 entries without)
// share one randomized stimulus stream and are checked against an array-level model.
module tb_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [9:0]  r_addr, w_addr;
    logic [63:0] w_data;
    logic [1:0]  w_ctrl;
    logic [63:0] r_data_a, r_data_b;
    logic        ready_a, ready_b;

    always #5 clk = ~clk;

    regfile_mp #(.REGISTER_COUNT(32), .DATA_LENGTH(32), .READ_PORTS(2), .WRITE_PORTS(2),
                 .ZERO_REG(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .r_addr_i(r_addr), .r_data_o(r_data_a),
        .w_addr_i(w_addr), .w_data_i(w_data), .w_ctrl_i(w_ctrl), .clr_i(clr),
        .ready_o(ready_a));

    regfile_mp #(.REGISTER_COUNT(24), .DATA_LENGTH(32), .READ_PORTS(2), .WRITE_PORTS(2),
                 .ZERO_REG(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .r_addr_i(r_addr), .r_data_o(r_data_b),
        .w_addr_i(w_addr), .w_data_i(w_data), .w_ctrl_i(w_ctrl), .clr_i(clr),
        .ready_o(ready_b));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: per instance, a plain array plus a countdown of busy cycles.
    int          rc [2] = '{32, 24};
    bit          zr [2] = '{1'b1, 1'b0};
    logic [31:0] mem [2][32];
    int          rem [2] = '{32, 24};

    function automatic logic [31:0] model_read(input int d, input logic [4:0] a);
        logic [31:0] v;
        if (rem[d] != 0 || int'(a) >= rc[d] || (zr[d] && a == 5'd0)) return 32'd0;
        v = mem[d][a];
`ifdef REGFILE_BYPASS_EN
        if (!rst && !clr) begin
            for (int j = 0; j < 2; j++) begin
                if (w_ctrl[j] && w_addr[j*AW +: AW] == a) v = w_data[j*DW +: DW];
            end
        end
`endif
        return v;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (rst || (rem[d] == 0 && clr)) begin
                rem[d] = rc[d];
                for (int k = 0; k < 32; k++) mem[d][k] = 32'd0;
            end else if (rem[d] > 0) begin
                rem[d]--;
            end else begin
                for (int j = 0; j < 2; j++) begin
                    if (w_ctrl[j] && int'(w_addr[j*AW +: AW]) < rc[d]
                        && !(zr[d] && w_addr[j*AW +: AW] == 5'd0))
                        mem[d][w_addr[j*AW +: AW]] = w_data[j*DW +: DW];
                end
            end
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model after the edge.
    task automatic cycle(input bit chk);
        @(negedge clk);
        #1;
        if (chk) begin
            check_eq("a.ready", 32'(ready_a), 32'(rem[0] == 0));
            check_eq("b.ready", 32'(ready_b), 32'(rem[1] == 0));
            for (int i = 0; i < 2; i++) begin
                check_eq($sformatf("a.rd%0d@%0d", i, r_addr[i*AW +: AW]),
                         r_data_a[i*DW +: DW], model_read(0, r_addr[i*AW +: AW]));
                check_eq($sformatf("b.rd%0d@%0d", i, r_addr[i*AW +: AW]),
                         r_data_b[i*DW +: DW], model_read(1, r_addr[i*AW +: AW]));
            end
        end
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic set_rd(input int i, input logic [4:0] a);
        r_addr[i*AW +: AW] = a;
    endtask

    task automatic set_wr(input int j, input logic [4:0] a, input logic [31:0] d, input bit en);
        w_addr[j*AW +: AW] = a;
        w_data[j*DW +: DW] = d;
        w_ctrl[j]          = en;
    endtask

    task automatic idle();
        rst = 1'b0;
        clr = 1'b0;
        w_ctrl = 2'b00;
    endtask

    task automatic rand_inputs(input bit allow_ctl);
        logic [4:0] a0;
        set_rd(0, 5'($urandom_range(0, 31)));
        set_rd(1, 5'($urandom_range(0, 31)));
        a0 = 5'($urandom_range(0, 31));
        set_wr(0, a0, $urandom, 1'($urandom));
        set_wr(1, ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31)),
               $urandom, 1'($urandom));
        // Reads frequently target a written address to exercise same-cycle behaviour.
        if ($urandom_range(0, 2) == 0) set_rd(1, w_addr[AW +: AW]);
        clr = allow_ctl && ($urandom_range(0, 49) == 0);
        rst = allow_ctl && ($urandom_range(0, 299) == 0);
    endtask

    logic [31:0] exp_same;

    initial begin
        r_addr = '0;
        w_addr = '0;
        w_data = '0;
        idle();

        // Reset, then scrub with writes attempted throughout.
        rst = 1'b1;
        cycle(1'b0);
        rst = 1'b0;
        for (int n = 0; n < 32; n++) begin
            rand_inputs(1'b0);
            if (n < 24) w_ctrl = 2'b00;
            cycle(1'b1);
        end
        idle();
        #1;
        check_eq("a.ready_after_32", 32'(ready_a), 32'd1);

        // Sweep every address on both ports of the 32-entry instance.
        for (int k = 0; k < 32; k += 2) begin
            set_rd(0, 5'(k));
            set_rd(1, 5'(k + 1));
            cycle(1'b1);
        end

        // Write then read, same cycle and next cycle.
        set_wr(0, 5'd5, 32'hDEADBEEF, 1'b1);
        set_rd(1, 5'd5);
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h0;
`endif
        check_eq("a.same_cycle_5", r_data_a[63:32], exp_same);
        cycle(1'b1);
        idle();
        #1;
        check_eq("a.next_cycle_5", r_data_a[63:32], 32'hDEADBEEF);

        // Write conflict on address 7.
        set_wr(0, 5'd7, 32'h11, 1'b1);
        set_wr(1, 5'd7, 32'h22, 1'b1);
        set_rd(0, 5'd7);
        cycle(1'b1);
        idle();
        #1;
        check_eq("a.conflict_7", r_data_a[31:0], 32'h22);
        check_eq("b.conflict_7", r_data_b[31:0], 32'h22);

        // Zero register.
        set_wr(0, 5'd0, 32'hFFFFFFFF, 1'b1);
        cycle(1'b1);
        idle();
        set_rd(0, 5'd0);
        #1;
        check_eq("a.zero_reg", r_data_a[31:0], 32'h0);
        check_eq("b.entry0", r_data_b[31:0], 32'hFFFFFFFF);

        // Out-of-range write on the 24-entry instance, in-range top entry.
        set_wr(0, 5'd30, 32'h00005A5A, 1'b1);
        set_wr(1, 5'd23, 32'hA5A5A5A5, 1'b1);
        cycle(1'b1);
        idle();
        set_rd(0, 5'd30);
        set_rd(1, 5'd23);
        #1;
        check_eq("b.addr30_dropped", r_data_b[31:0], 32'h0);
        check_eq("b.addr23", r_data_b[63:32], 32'hA5A5A5A5);
        check_eq("a.addr30", r_data_a[31:0], 32'h00005A5A);

        // Clear: load, pulse clr with a colliding write, then scrub with writes attempted.
        set_wr(0, 5'd3, 32'h1234, 1'b1);
        cycle(1'b1);
        idle();
        clr = 1'b1;
        set_wr(1, 5'd9, 32'h0BAD, 1'b1);
        cycle(1'b1);
        for (int n = 0; n < 32; n++) begin
            rand_inputs(1'b0);
            cycle(1'b1);
        end
        idle();
        set_rd(0, 5'd3);
        #1;
        check_eq("a.ready_after_clr", 32'(ready_a), 32'd1);
        check_eq("a.addr3_cleared", r_data_a[31:0], 32'h0);

        // Reset at scrub cycle 10.
        clr = 1'b1;
        cycle(1'b1);
        clr = 1'b0;
        for (int n = 0; n < 10; n++) cycle(1'b1);
        rst = 1'b1;
        cycle(1'b1);
        rst = 1'b0;
        for (int n = 0; n < 31; n++) cycle(1'b1);
        #1;
        check_eq("a.ready_31_after_rst", 32'(ready_a), 32'd0);
        cycle(1'b1);
        #1;
        check_eq("a.ready_32_after_rst", 32'(ready_a), 32'd1);

        // Randomized traffic with occasional clear and reset.
        for (int n = 0; n < 3000; n++) begin
            rand_inputs(1'b1);
            cycle(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Multi-port, parametrised integer register file for the RV32I core and its wider-issue follow-ons.
- Configurable number of combinational read ports and clocked write ports; deterministic priority between write ports.
- Optional hardwired zero register.
- Built-in scrub state machine zeroes every entry after reset or on request; a ready flag holds off the pipeline until the scrub completes.

Parameters:
- REGISTER_COUNT, 32, number of entries (need not be a power of two).
- DATA_LENGTH, 32, bits per entry.
- READ_PORTS, 2, number of read ports (>=1).
- WRITE_PORTS, 2, number of write ports (>=1).
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register.
- Derived: AW = $clog2(REGISTER_COUNT).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- r_addr  input  READ_PORTS*AW  read addresses; port i at [i*AW +: AW].
- r_data  output  READ_PORTS*DATA_LENGTH  read data; port i at [i*DATA_LENGTH +: DATA_LENGTH].
- w_addr  input  WRITE_PORTS*AW  write addresses, packed as for r_addr.
- w_data  input  WRITE_PORTS*DATA_LENGTH  write data, packed.
- w_ctrl  input  WRITE_PORTS  per-port write enable.
- clr  input  1  single-cycle request to re-scrub the array.
- ready  output  1  high when the array is usable.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.

FSM:
- Two states, SCRUB and READY, plus a scrub counter of width AW.

Reset:
- rst=1 at an edge: state <= SCRUB, counter <= 0, ready <= 0.
- rst has priority over everything else.
- rst asserted mid-scrub restarts the counter at 0.

SCRUB:
- Each cycle: entry[counter] <= 0, then counter <= counter+1.
- On the edge that writes entry REGISTER_COUNT-1: state <= READY, ready <= 1.
- ready therefore rises exactly REGISTER_COUNT edges after the first edge with rst=0.
- w_ctrl is ignored in SCRUB; no user write lands.
- All r_data read 0 in SCRUB.
- clr is ignored in SCRUB.

READY:
- clr=1 at an edge: state <= SCRUB, counter <= 0, ready <= 0.
- User writes in that same cycle are dropped.

Reads:
- Combinational, zero latency: r_data[i] = entry[r_addr[i]].
- Reads return 0 when any of these holds:
  - r_addr >= REGISTER_COUNT;
  - ZERO_REG=1 and r_addr=0;
  - state is SCRUB.
- A same-cycle write is not visible until after the edge, unless the optional bypass is compiled in.

Writes:
- Port j writes at the edge when w_ctrl[j]=1 and state is READY.
- A write is dropped if w_addr[j] >= REGISTER_COUNT, or if ZERO_REG=1 and w_addr[j]=0.
- Several ports writing the same address in one cycle: the highest-index port wins; the others are discarded.

Arithmetic/width:
- No data transformation; entries are stored exactly as written.
- The counter comparison uses REGISTER_COUNT-1, so non-power-of-two counts stop correctly without wrap.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose address matches an enabled, non-dropped write in the same cycle returns that write's w_data combinationally; with multiple matches, the highest-index write port wins.
  - No bypass in SCRUB, for dropped writes, or for the zero register.
- Undefined: reads return only stored contents; the new value appears in the cycle after the write edge.

Test Plan:
- Reset then ready timing: rst=1 for 1 cycle, then rst=0 -> ready=0 for exactly 32 edges, ready=1 after the 32nd; every address reads 0x00000000 on both ports.
- Write/read: port0 writes addr 5 = 0xDEADBEEF.
  - Same cycle, port1 reading addr 5 -> 0x00000000 without REGFILE_BYPASS_EN, 0xDEADBEEF with it.
  - Next cycle -> 0xDEADBEEF in both builds.
- Write conflict: port0 writes addr 7 = 0x11 and port1 writes addr 7 = 0x22 in the same cycle -> addr 7 reads 0x22; with bypass, the same-cycle read is also 0x22.
- Zero register: write addr 0 = 0xFFFFFFFF.
  - ZERO_REG=1 -> reads 0x00000000.
  - ZERO_REG=0 -> reads 0xFFFFFFFF.
- Clear and reset mid-scrub:
  - Load addr 3 = 0x1234, then pulse clr -> ready=0 for 32 edges; writes during scrub are ignored; addr 3 reads 0 afterwards.
  - Assert rst at scrub cycle 10 -> ready rises 32 edges after rst deasserts.
- Non-power-of-two: REGISTER_COUNT=24 -> ready after 24 edges; a write to addr 30 is dropped and addr 30 reads 0; addr 23 = 0xA5A5A5A5 reads back correctly.
